// File: rtl/vga_text_pkg.sv
// Shared constants and types for the text-mode framebuffer and its SPI feeder.
package vga_text_pkg;

  localparam int unsigned SCREEN_COLS = 80;
  localparam int unsigned SCREEN_ROWS = 30;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} spi_tx_state_t;

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous first-word-fall-through FIFO buffering bytes for spi_text_tx.
module spi_tx_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AddrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_text_tx.sv
// SPI mode-0 byte transmitter feeding the text framebuffer; tracks the next screen cell.
// Define SPI_TX_FIFO_EN for a FIFO_DEPTH-entry buffer instead of a single holding register.
module spi_text_tx
  import vga_text_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned SCREEN_CHARS = SCREEN_COLS * SCREEN_ROWS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        spi_sck,
  output logic                        spi_mosi,
  output logic                        spi_ssel_n,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic [11:0]                 tx_count
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DivW = $clog2(CLK_DIV) + 1;

  logic       push, pop, full, empty;
  logic [7:0] buf_data;

  assign push = in_valid && in_ready;

`ifdef SPI_TX_FIFO_EN
  spi_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (in_data),
    .pop_i   (pop),
    .data_o  (buf_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
`else
  logic       hold_valid_q;
  logic [7:0] hold_data_q;

  // push and pop are mutually exclusive here: push needs the register empty, pop needs it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (push) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= in_data;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign buf_data = hold_data_q;
  assign full     = hold_valid_q;
  assign empty    = !hold_valid_q;
  assign level    = LvlW'(hold_valid_q);
`endif

  assign in_ready = !full;

  spi_tx_state_t   state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic            high_q, high_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [11:0]     count_d;
  logic            div_last;
  logic            sck_d, mosi_d, ssel_n_d;

  assign div_last = (div_q == DivW'(CLK_DIV - 1));
  assign busy     = (state_q != IDLE) || !empty;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    high_d  = high_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    count_d = tx_count;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = buf_data;
          div_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_last) begin
          div_d   = '0;
          high_d  = 1'b1;
          bit_d   = 3'd7;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (!div_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (high_q) begin
            // Next bit is presented on entry to the low phase; bit0 is held to the end.
            high_d = 1'b0;
            if (bit_q != 3'd0) shreg_d = {shreg_q[6:0], 1'b0};
          end else if (bit_q == 3'd0) begin
            state_d = GAP;
            count_d = (tx_count == 12'(SCREEN_CHARS - 1)) ? 12'd0 : tx_count + 12'd1;
          end else begin
            high_d = 1'b1;
            bit_d  = bit_q - 3'd1;
          end
        end
      end
      GAP: begin
        if (div_last) begin
          div_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = buf_data;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pins are registered from the next state so they change on the same edge as the FSM.
    sck_d    = (state_d == SHIFT) && high_d;
    mosi_d   = ((state_d == SETUP) || (state_d == SHIFT)) && shreg_d[7];
    ssel_n_d = !((state_d == SETUP) || (state_d == SHIFT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      high_q     <= 1'b0;
      bit_q      <= '0;
      shreg_q    <= '0;
      tx_count   <= '0;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_ssel_n <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      high_q     <= high_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      tx_count   <= count_d;
      spi_sck    <= sck_d;
      spi_mosi   <= mosi_d;
      spi_ssel_n <= ssel_n_d;
    end
  end

endmodule

// File: tb/tb_spi_text_tx.sv
// Scoreboard bench for spi_text_tx: random bytes in, SPI frames decoded and compared.
module tb_spi_text_tx;

  localparam int CD    = 2;
  localparam int DEPTH = 16;
  localparam int SC    = 10;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef SPI_TX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic          clk, rst;
  logic [7:0]    in_data;
  logic          in_valid, in_ready;
  logic          spi_sck, spi_mosi, spi_ssel_n, busy;
  logic [LW-1:0] level;
  logic [11:0]   tx_count;

  spi_text_tx #(
    .CLK_DIV      (CD),
    .FIFO_DEPTH   (DEPTH),
    .SCREEN_CHARS (SC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_ssel_n (spi_ssel_n),
    .busy       (busy),
    .level      (level),
    .tx_count   (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard state shared between stimulus and monitor.
  logic [7:0] exp_q[$];
  int         falls[$];
  int         cyc = 0;
  int         frames_done = 0;
  int         max_level = 0;
  bit         saw_not_ready = 0;
  int         nbits = 0;
  int         low_cnt = 0;
  logic [7:0] shv;
  logic       prev_sck = 0, prev_ssel = 1, prev_mosi = 0;

  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (rst) begin
      prev_sck    = 0;
      prev_ssel   = 1;
      prev_mosi   = 0;
      nbits       = 0;
      low_cnt     = 0;
      frames_done = 0;
    end else begin
      check_eq("in_ready_vs_level", in_ready, (level != CAP) ? 1 : 0);
      if (level > max_level) max_level = level;
      if (!in_ready) saw_not_ready = 1;
      if (!spi_ssel_n) begin
        if (prev_ssel) begin
          falls.push_back(cyc);
          nbits   = 0;
          low_cnt = 0;
        end
        low_cnt++;
        if (spi_sck && !prev_sck) begin
          check_eq("mosi_stable_before_rise", spi_mosi, prev_mosi);
          shv = {shv[6:0], spi_mosi};
          nbits++;
        end
      end else begin
        check_eq("sck_idle_low", spi_sck, 0);
        if (!prev_ssel) begin
          check_eq("frame_bits", nbits, 8);
          check_eq("ssel_low_cycles", low_cnt, 17 * CD);
          if (exp_q.size() == 0) begin
            fail_now("unexpected_frame");
          end else begin
            e = exp_q.pop_front();
            check_eq("frame_byte", shv, e);
          end
          frames_done = (frames_done + 1) % SC;
          check_eq("tx_count_at_gap", tx_count, frames_done);
        end
      end
      prev_sck  = spi_sck;
      prev_ssel = spi_ssel_n;
      prev_mosi = spi_mosi;
    end
  end

  int total = 0;

  task automatic push(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      fail_now("push_wait");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(b);
      total++;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 5000) begin
      @(posedge clk);
      #1 t++;
    end
    if (t >= 5000) fail_now("drain");
  endtask

  initial begin
    int t;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sck", spi_sck, 0);
    check_eq("rst_mosi", spi_mosi, 0);
    check_eq("rst_ssel_n", spi_ssel_n, 1);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_tx_count", tx_count, 0);
    @(negedge clk) rst = 1'b0;

    // Single byte: latency from push to ssel_n fall, then GAP length until busy drops.
    push(8'h41);
    check_eq("single_level_after_push", level, 1);
    check_eq("single_ssel_before_pop", spi_ssel_n, 1);
    @(posedge clk);
    #1;
    check_eq("single_ssel_fell", spi_ssel_n, 0);
    check_eq("single_level_after_pop", level, 0);
    t = 0;
    while (!spi_ssel_n && t < 200) begin
      @(posedge clk);
      #1 t++;
    end
    if (t >= 200) fail_now("single_ssel_rise");
    t = 0;
    while (busy && t < 100) begin
      @(posedge clk);
      #1 t++;
    end
    check_eq("single_gap_to_idle", t, CD);
    check_eq("single_tx_count", tx_count, 1);
    drain();

    // Burst of three consecutive pushes: frames back to back.
    falls.delete();
    max_level = 0;
    push(8'h48);
    push(8'h49);
    push(8'h21);
    drain();
    check_eq("burst_frames", falls.size(), 3);
    if (falls.size() == 3) begin
      check_eq("burst_spacing_1", falls[1] - falls[0], 18 * CD);
      check_eq("burst_spacing_2", falls[2] - falls[1], 18 * CD);
    end
    check_eq("burst_level_peak", max_level, (CAP > 1) ? 2 : 1);

    // Continuous stream: buffer must fill and backpressure without loss.
    max_level     = 0;
    saw_not_ready = 0;
    for (int i = 0; i < 40; i++) push(8'($urandom));
    drain();
    check_eq("stream_level_peak", max_level, CAP);
    check_eq("stream_backpressure_seen", saw_not_ready, 1);

    // Random bytes with random idle gaps, crossing the tx_count wrap.
    for (int i = 0; i < 20; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    drain();
    check_eq("tx_count_after_random", tx_count, total % SC);

    // Reset in the middle of a frame with a second byte buffered.
    push(8'h5A);
    push(8'hC3);
    t = 0;
    while (nbits < 4 && t < 500) begin
      @(posedge clk);
      #1 t++;
    end
    if (t >= 500) fail_now("wait_bit4");
    check_eq("pre_reset_level", level, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_ssel_n", spi_ssel_n, 1);
    check_eq("midrst_sck", spi_sck, 0);
    check_eq("midrst_level", level, 0);
    check_eq("midrst_tx_count", tx_count, 0);
    check_eq("midrst_busy", busy, 0);
    exp_q.delete();
    total = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    push(8'h3C);
    drain();
    check_eq("post_reset_tx_count", tx_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    fail_now("watchdog");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
